// File: rtl/lsu_axi_param.sv
// Load/store unit bridging a single RISC-V memory request to one AXI4 single-beat transaction.
// Handles alignment checks, lane steering, load extension, bus errors and R/B timeouts.
module lsu_axi_param #(
   parameter int          DATA_W  = 32,
   parameter logic [3:0]  AXI_ID  = 4'b0001,
   parameter int          TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_addr,
   input  logic [DATA_W-1:0]     in_wdata,
   input  logic [2:0]            in_funct3,
   input  logic                  in_is_load,
   input  logic                  in_is_store,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_rdata,
   output logic [1:0]            out_err,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [31:0]           araddr,
   output logic [3:0]            arid,
   output logic [2:0]            arsize,
   output logic [7:0]            arlen,
   output logic [1:0]            arburst,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [DATA_W-1:0]     rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [31:0]           awaddr,
   output logic [3:0]            awid,
   output logic [2:0]            awsize,
   output logic [7:0]            awlen,
   output logic [1:0]            awburst,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   input  logic                  bvalid,
   output logic                  bready,
   input  logic [1:0]            bresp
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LANE_W = $clog2(STRB_W);
   localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_t;

   state_t               state_reg;
   logic [31:0]          addr_reg;
   logic [2:0]           funct3_reg;
   logic [DATA_W-1:0]    wdata_reg;
   logic [DATA_W-1:0]    rdata_reg;
   logic [1:0]           err_reg;
   logic                 arvalid_reg;
   logic                 awvalid_reg;
   logic                 wvalid_reg;
   logic [TCNT_W-1:0]    tcnt_reg;

   logic [2:0]           in_size_mask;
   logic                 in_misaligned;
   logic                 in_illegal;
   logic                 timeout_hit;
   logic [LANE_W-1:0]    lane_off;
   logic [DATA_W-1:0]    r_shift;
   logic [DATA_W-1:0]    r_ext;
   logic [7:0]           strb_base;
   logic [DATA_W-1:0]    wdata_rep;

   assign in_size_mask  = 3'((4'd1 << in_funct3[1:0]) - 4'd1);
   assign in_misaligned = |(in_addr[2:0] & in_size_mask);
   assign in_illegal    = (in_funct3 == 3'b111) || (in_is_store && in_funct3[2]) ||
                          ((DATA_W == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
   assign timeout_hit   = (TIMEOUT != 0) && (tcnt_reg == TCNT_W'(TIMEOUT - 1));

   // Loads: move the addressed lane down to bit 0, then extend per funct3.
   assign lane_off = addr_reg[LANE_W-1:0];
   assign r_shift  = rdata >> {lane_off, 3'b000};

   always_comb begin
      r_ext = r_shift;
      case (funct3_reg)
         3'b000:  r_ext = DATA_W'($signed(r_shift[7:0]));
         3'b001:  r_ext = DATA_W'($signed(r_shift[15:0]));
         3'b010:  r_ext = DATA_W'($signed(r_shift[31:0]));
         3'b100:  r_ext = DATA_W'(r_shift[7:0]);
         3'b101:  r_ext = DATA_W'(r_shift[15:0]);
         3'b110:  r_ext = DATA_W'(r_shift[31:0]);
         default: r_ext = r_shift;
      endcase
   end

   always_comb begin
      case (funct3_reg[1:0])
         2'd0:    strb_base = 8'h01;
         2'd1:    strb_base = 8'h03;
         2'd2:    strb_base = 8'h0F;
         default: strb_base = 8'hFF;
      endcase
   end

   // Stores: replicate the low `size` bytes across every lane so any lane offset sees the data.
   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] =
         (funct3_reg[1:0] == 2'd0) ? wdata_reg[7:0] :
         (funct3_reg[1:0] == 2'd1) ? wdata_reg[8*(gi%2) +: 8] :
         (funct3_reg[1:0] == 2'd2) ? wdata_reg[8*(gi%4) +: 8] :
                                     wdata_reg[8*(gi%8) +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         addr_reg    <= '0;
         funct3_reg  <= '0;
         wdata_reg   <= '0;
         rdata_reg   <= '0;
         err_reg     <= 2'b00;
         arvalid_reg <= 1'b0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         tcnt_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  addr_reg   <= in_addr;
                  funct3_reg <= in_funct3;
                  wdata_reg  <= in_wdata;
                  rdata_reg  <= '0;
                  err_reg    <= 2'b00;
                  tcnt_reg   <= '0;
                  if (!in_is_load && !in_is_store) begin
                     state_reg <= S_DONE;
                  end else if (in_misaligned || in_illegal) begin
                     err_reg   <= 2'b01;
                     state_reg <= S_DONE;
                  end else if (in_is_load) begin
                     arvalid_reg <= 1'b1;
                     state_reg   <= S_AR;
                  end else begin
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= S_AWW;
                  end
               end
            end
            S_AR: begin
               if (arready) begin
                  arvalid_reg <= 1'b0;
                  tcnt_reg    <= '0;
                  state_reg   <= S_R;
               end
            end
            S_R: begin
               if (rvalid && rlast) begin
                  if (rresp != 2'b00) begin
                     err_reg   <= 2'b10;
                     rdata_reg <= '0;
                  end else begin
                     rdata_reg <= r_ext;
                  end
                  state_reg <= S_DONE;
               end else if (timeout_hit) begin
                  err_reg   <= 2'b11;
                  state_reg <= S_DONE;
               end else begin
                  tcnt_reg <= tcnt_reg + 1'b1;
               end
            end
            S_AWW: begin
               // AW and W retire independently; move on once neither is still pending.
               if (awready) awvalid_reg <= 1'b0;
               if (wready)  wvalid_reg  <= 1'b0;
               if ((!awvalid_reg || awready) && (!wvalid_reg || wready)) begin
                  tcnt_reg  <= '0;
                  state_reg <= S_B;
               end
            end
            S_B: begin
               if (bvalid) begin
                  if (bresp != 2'b00) err_reg <= 2'b10;
                  state_reg <= S_DONE;
               end else if (timeout_hit) begin
                  err_reg   <= 2'b11;
                  state_reg <= S_DONE;
               end else begin
                  tcnt_reg <= tcnt_reg + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Ready is held high in IDLE so stale responses from timed-out requests drain silently.
   assign in_ready  = (state_reg == S_IDLE);
   assign out_valid = (state_reg == S_DONE);
   assign rready    = (state_reg == S_IDLE) || (state_reg == S_R);
   assign bready    = (state_reg == S_IDLE) || (state_reg == S_B);
   assign out_rdata = rdata_reg;
   assign out_err   = err_reg;

   assign arvalid = arvalid_reg;
   assign araddr  = addr_reg;
   assign arid    = AXI_ID;
   assign arsize  = {1'b0, funct3_reg[1:0]};
   assign arlen   = 8'd0;
   assign arburst = 2'b01;
   assign awvalid = awvalid_reg;
   assign awaddr  = addr_reg;
   assign awid    = AXI_ID;
   assign awsize  = {1'b0, funct3_reg[1:0]};
   assign awlen   = 8'd0;
   assign awburst = 2'b01;
   assign wvalid  = wvalid_reg;
   assign wlast   = wvalid_reg;
   assign wdata   = wdata_rep;
   assign wstrb   = STRB_W'(strb_base << lane_off);

endmodule

// File: tb/tb_lsu_axi_param.sv
// Directed bench for lsu_axi_param: a 32-bit instance with TIMEOUT=8 and a 64-bit instance.
module tb_lsu_axi_param;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // 32-bit instance signals
   logic        a_in_valid = 0, a_in_ready, a_in_is_load = 0, a_in_is_store = 0;
   logic [31:0] a_in_addr = 0, a_in_wdata = 0;
   logic [2:0]  a_in_funct3 = 0;
   logic        a_out_valid, a_out_ready = 0;
   logic [31:0] a_out_rdata;
   logic [1:0]  a_out_err;
   logic        a_arvalid, a_arready = 1, a_rvalid = 0, a_rready, a_rlast = 0;
   logic [31:0] a_araddr, a_rdata = 0;
   logic [3:0]  a_arid;
   logic [2:0]  a_arsize;
   logic [7:0]  a_arlen;
   logic [1:0]  a_arburst, a_rresp = 0;
   logic        a_awvalid, a_awready = 1, a_wvalid, a_wready = 1, a_wlast, a_bvalid = 0, a_bready;
   logic [31:0] a_awaddr, a_wdata;
   logic [3:0]  a_awid, a_wstrb;
   logic [2:0]  a_awsize;
   logic [7:0]  a_awlen;
   logic [1:0]  a_awburst, a_bresp = 0;

   // 64-bit instance signals
   logic        b_in_valid = 0, b_in_ready, b_in_is_load = 0, b_in_is_store = 0;
   logic [31:0] b_in_addr = 0;
   logic [63:0] b_in_wdata = 0;
   logic [2:0]  b_in_funct3 = 0;
   logic        b_out_valid, b_out_ready = 0;
   logic [63:0] b_out_rdata;
   logic [1:0]  b_out_err;
   logic        b_arvalid, b_arready = 1, b_rvalid = 0, b_rready, b_rlast = 0;
   logic [31:0] b_araddr;
   logic [63:0] b_rdata = 0;
   logic [3:0]  b_arid;
   logic [2:0]  b_arsize;
   logic [7:0]  b_arlen;
   logic [1:0]  b_arburst, b_rresp = 0;
   logic        b_awvalid, b_awready = 1, b_wvalid, b_wready = 1, b_wlast, b_bvalid = 0, b_bready;
   logic [31:0] b_awaddr;
   logic [63:0] b_wdata;
   logic [3:0]  b_awid;
   logic [7:0]  b_wstrb;
   logic [2:0]  b_awsize;
   logic [7:0]  b_awlen;
   logic [1:0]  b_awburst, b_bresp = 0;

   lsu_axi_param #(.DATA_W(32), .AXI_ID(4'b0001), .TIMEOUT(8)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr), .in_wdata(a_in_wdata),
      .in_funct3(a_in_funct3), .in_is_load(a_in_is_load), .in_is_store(a_in_is_store),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_rdata(a_out_rdata), .out_err(a_out_err),
      .arvalid(a_arvalid), .arready(a_arready), .araddr(a_araddr), .arid(a_arid), .arsize(a_arsize),
      .arlen(a_arlen), .arburst(a_arburst),
      .rvalid(a_rvalid), .rready(a_rready), .rdata(a_rdata), .rresp(a_rresp), .rlast(a_rlast),
      .awvalid(a_awvalid), .awready(a_awready), .awaddr(a_awaddr), .awid(a_awid), .awsize(a_awsize),
      .awlen(a_awlen), .awburst(a_awburst),
      .wvalid(a_wvalid), .wready(a_wready), .wdata(a_wdata), .wstrb(a_wstrb), .wlast(a_wlast),
      .bvalid(a_bvalid), .bready(a_bready), .bresp(a_bresp)
   );

   lsu_axi_param #(.DATA_W(64), .AXI_ID(4'b0101), .TIMEOUT(1024)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_wdata(b_in_wdata),
      .in_funct3(b_in_funct3), .in_is_load(b_in_is_load), .in_is_store(b_in_is_store),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_rdata(b_out_rdata), .out_err(b_out_err),
      .arvalid(b_arvalid), .arready(b_arready), .araddr(b_araddr), .arid(b_arid), .arsize(b_arsize),
      .arlen(b_arlen), .arburst(b_arburst),
      .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rresp(b_rresp), .rlast(b_rlast),
      .awvalid(b_awvalid), .awready(b_awready), .awaddr(b_awaddr), .awid(b_awid), .awsize(b_awsize),
      .awlen(b_awlen), .awburst(b_awburst),
      .wvalid(b_wvalid), .wready(b_wready), .wdata(b_wdata), .wstrb(b_wstrb), .wlast(b_wlast),
      .bvalid(b_bvalid), .bready(b_bready), .bresp(b_bresp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_req(input logic [31:0] addr, input logic [2:0] f3, input logic ld,
                        input logic st, input logic [31:0] wd);
      chk("a_in_ready", a_in_ready, 1);
      a_in_valid = 1; a_in_addr = addr; a_in_funct3 = f3;
      a_in_is_load = ld; a_in_is_store = st; a_in_wdata = wd;
      step();
      a_in_valid = 0; a_in_is_load = 0; a_in_is_store = 0;
      $display("txn A32 addr=%h funct3=%b load=%0d store=%0d wdata=%h", addr, f3, ld, st, wd);
   endtask

   task automatic b_req(input logic [31:0] addr, input logic [2:0] f3, input logic ld,
                        input logic st, input logic [63:0] wd);
      chk("b_in_ready", b_in_ready, 1);
      b_in_valid = 1; b_in_addr = addr; b_in_funct3 = f3;
      b_in_is_load = ld; b_in_is_store = st; b_in_wdata = wd;
      step();
      b_in_valid = 0; b_in_is_load = 0; b_in_is_store = 0;
      $display("txn B64 addr=%h funct3=%b load=%0d store=%0d wdata=%h", addr, f3, ld, st, wd);
   endtask

   task automatic a_release();
      a_out_ready = 1;
      step();
      a_out_ready = 0;
      chk("a_back_idle_valid", a_out_valid, 0);
      chk("a_back_idle_ready", a_in_ready, 1);
   endtask

   task automatic b_release();
      b_out_ready = 1;
      step();
      b_out_ready = 0;
      chk("b_back_idle_valid", b_out_valid, 0);
   endtask

   // Load with arready high: accept, AR, R, then out_valid in the fourth cycle.
   task automatic a_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rd,
                         input logic [1:0] rr, input logic [31:0] exp_rd, input logic [1:0] exp_err);
      a_req(addr, f3, 1, 0, 0);
      chk("a_arvalid", a_arvalid, 1);
      chk("a_araddr", a_araddr, addr);
      chk("a_arsize", a_arsize, {1'b0, f3[1:0]});
      step();
      chk("a_ar_drop", a_arvalid, 0);
      chk("a_rready_in_r", a_rready, 1);
      chk("a_not_done_yet", a_out_valid, 0);
      a_rvalid = 1; a_rdata = rd; a_rresp = rr; a_rlast = 1;
      step();
      a_rvalid = 0; a_rlast = 0; a_rresp = 0;
      chk("a_ld_valid", a_out_valid, 1);
      chk("a_ld_rdata", a_out_rdata, exp_rd);
      chk("a_ld_err", a_out_err, exp_err);
   endtask

   task automatic b_load(input logic [31:0] addr, input logic [2:0] f3, input logic [63:0] rd,
                         input logic [1:0] rr, input logic [63:0] exp_rd, input logic [1:0] exp_err);
      b_req(addr, f3, 1, 0, 0);
      chk("b_arvalid", b_arvalid, 1);
      chk("b_arsize", b_arsize, {1'b0, f3[1:0]});
      chk("b_arid", b_arid, 4'b0101);
      step();
      b_rvalid = 1; b_rdata = rd; b_rresp = rr; b_rlast = 1;
      step();
      b_rvalid = 0; b_rlast = 0; b_rresp = 0;
      chk("b_ld_valid", b_out_valid, 1);
      chk("b_ld_rdata", b_out_rdata, exp_rd);
      chk("b_ld_err", b_out_err, exp_err);
      b_release();
   endtask

   // Request that must finish immediately without touching the bus.
   task automatic a_short(input logic [31:0] addr, input logic [2:0] f3, input logic ld,
                          input logic st, input logic [1:0] exp_err);
      a_req(addr, f3, ld, st, 32'hFFFF_FFFF);
      chk("a_short_valid", a_out_valid, 1);
      chk("a_short_err", a_out_err, exp_err);
      chk("a_short_rdata", a_out_rdata, 0);
      chk("a_short_no_ar", a_arvalid, 0);
      chk("a_short_no_aw", a_awvalid, 0);
      a_release();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step(); step();
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_arvalid", a_arvalid, 0);
      chk("rst_awvalid", a_awvalid, 0);
      chk("rst_wvalid", a_wvalid, 0);
      chk("rst_rready", a_rready, 1);
      chk("rst_bready", a_bready, 1);
      chk("rst_err", a_out_err, 0);
      chk("rst_rdata", a_out_rdata, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
      rst = 0;
      step();

      // LB sign-extended from lane 3, then hold while out_ready is low
      a_load(32'h8000_0003, 3'b000, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 2'b00);
      chk("a_arlen", a_arlen, 0);
      chk("a_arburst", a_arburst, 2'b01);
      step();
      chk("a_hold_valid", a_out_valid, 1);
      chk("a_hold_rdata", a_out_rdata, 32'hFFFF_FF80);
      chk("a_hold_err", a_out_err, 0);
      a_release();
      a_load(32'h1000_0002, 3'b101, 32'hBEEF_1234, 2'b00, 32'h0000_BEEF, 2'b00);
      a_release();
      a_load(32'h1000_0002, 3'b001, 32'hBEEF_1234, 2'b00, 32'hFFFF_BEEF, 2'b00);
      a_release();
      a_load(32'h0000_0040, 3'b010, 32'h1234_5678, 2'b10, 32'h0, 2'b10);
      a_release();

      // Misaligned, illegal encodings and a request that is neither load nor store
      a_short(32'h8000_0001, 3'b010, 1, 0, 2'b01);
      a_short(32'h0000_0000, 3'b011, 1, 0, 2'b01);
      a_short(32'h0000_0000, 3'b110, 1, 0, 2'b01);
      a_short(32'h0000_0000, 3'b100, 0, 1, 2'b01);
      a_short(32'h0000_0003, 3'b111, 1, 0, 2'b01);
      a_short(32'h0000_0000, 3'b010, 0, 0, 2'b00);

      // SH with awready held off for three cycles, wready immediate
      a_awready = 0;
      a_req(32'h8000_0002, 3'b001, 0, 1, 32'h0000_1234);
      chk("sh_awvalid", a_awvalid, 1);
      chk("sh_wvalid", a_wvalid, 1);
      chk("sh_wstrb", a_wstrb, 4'b1100);
      chk("sh_wdata", a_wdata, 32'h1234_1234);
      chk("sh_awaddr", a_awaddr, 32'h8000_0002);
      chk("sh_awsize", a_awsize, 3'd1);
      chk("sh_wlast", a_wlast, 1);
      chk("sh_awid", a_awid, 4'b0001);
      step();
      chk("sh_w_dropped", a_wvalid, 0);
      chk("sh_aw_held", a_awvalid, 1);
      step();
      step();
      chk("sh_aw_held3", a_awvalid, 1);
      a_awready = 1;
      step();
      chk("sh_aw_dropped", a_awvalid, 0);
      chk("sh_bready", a_bready, 1);
      chk("sh_in_b", a_out_valid, 0);
      a_bvalid = 1; a_bresp = 2'b00;
      step();
      a_bvalid = 0;
      chk("sh_valid", a_out_valid, 1);
      chk("sh_err", a_out_err, 0);
      chk("sh_rdata", a_out_rdata, 0);
      a_release();

      // SB at lane 3
      a_req(32'h0000_0003, 3'b000, 0, 1, 32'h0000_00A5);
      chk("sb_wstrb", a_wstrb, 4'b1000);
      chk("sb_wdata", a_wdata, 32'hA5A5_A5A5);
      step();
      a_bvalid = 1;
      step();
      a_bvalid = 0;
      chk("sb_err", a_out_err, 0);
      a_release();

      // SW with both handshakes in one cycle and an error response on B
      a_req(32'h2000_0004, 3'b010, 0, 1, 32'hDEAD_BEEF);
      chk("sw_wstrb", a_wstrb, 4'b1111);
      chk("sw_wdata", a_wdata, 32'hDEAD_BEEF);
      step();
      chk("sw_aw_done", a_awvalid, 0);
      chk("sw_w_done", a_wvalid, 0);
      a_bvalid = 1; a_bresp = 2'b10;
      step();
      a_bvalid = 0; a_bresp = 2'b00;
      chk("sw_berr", a_out_err, 2'b10);
      chk("sw_berr_rdata", a_out_rdata, 0);
      a_release();

      // Load whose R never arrives: eight cycles in R, then timeout
      a_req(32'h0000_0100, 3'b010, 1, 0, 0);
      step();
      for (int i = 0; i < 7; i++) step();
      chk("to_still_waiting", a_out_valid, 0);
      step();
      chk("to_valid", a_out_valid, 1);
      chk("to_err", a_out_err, 2'b11);
      chk("to_rdata", a_out_rdata, 0);
      a_release();
      a_rvalid = 1; a_rdata = 32'hCAFE_F00D; a_rlast = 1;
      chk("stale_rready", a_rready, 1);
      step();
      a_rvalid = 0; a_rlast = 0;
      chk("stale_no_valid", a_out_valid, 0);
      step();
      chk("stale_no_valid2", a_out_valid, 0);
      a_load(32'h0000_0001, 3'b100, 32'h0000_AB00, 2'b00, 32'h0000_00AB, 2'b00);
      a_release();

      // 64-bit instance
      b_load(32'h8000_0008, 3'b011, 64'h1122_3344_5566_7788, 2'b10, 64'h0, 2'b10);
      b_load(32'h8000_0004, 3'b010, 64'h8000_0001_0000_0000, 2'b00, 64'hFFFF_FFFF_8000_0001, 2'b00);
      b_load(32'h8000_0004, 3'b110, 64'h8000_0001_0000_0000, 2'b00, 64'h0000_0000_8000_0001, 2'b00);
      b_load(32'h8000_0000, 3'b011, 64'h1122_3344_5566_7788, 2'b00, 64'h1122_3344_5566_7788, 2'b00);
      b_req(32'h0000_0005, 3'b000, 0, 1, 64'h0000_0000_0000_00AB);
      chk("b_sb_wstrb", b_wstrb, 8'h20);
      chk("b_sb_wdata", b_wdata, 64'hABAB_ABAB_ABAB_ABAB);
      step();
      b_bvalid = 1;
      step();
      b_bvalid = 0;
      chk("b_sb_valid", b_out_valid, 1);
      chk("b_sb_err", b_out_err, 0);
      b_release();

      // Reset while waiting in B
      a_req(32'h0000_0000, 3'b010, 0, 1, 32'h1);
      step();
      chk("rstb_in_b_bready", a_bready, 1);
      chk("rstb_in_b_valid", a_out_valid, 0);
      rst = 1;
      step();
      chk("rstb_in_ready", a_in_ready, 1);
      chk("rstb_bready", a_bready, 1);
      chk("rstb_out_valid", a_out_valid, 0);
      chk("rstb_awvalid", a_awvalid, 0);
      rst = 0;
      step();
      chk("rstb_idle_after", a_in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
